dense_argmax_axis: RTL and testbench

- Classification stage directly downstream of the Dense layer's AXI-Stream output.
- Consumes one frame of CLASS_COUNT signed fixed-point scores, one score per beat, and tracks the running maximum.
- Emits the winning class index, its score and a framing-error flag as a single output transaction.
- Final stage of the MNIST inference pipeline; its result goes to the host/AXI side.

---
 rtl/dense_pkg.sv | 14 +
 rtl/dense_argmax_axis.sv | 130 +++++++++++++
 tb/tb_dense_argmax_axis.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the Dense layer and its argmax classification stage.
// Holds the argmax FSM state encoding and the default score width / class count.
package dense_pkg;

  localparam int DENSE_DATA_SIZE   = 16;
  localparam int DENSE_CLASS_COUNT = 10;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/dense_argmax_axis.sv
// Argmax over one AXI-Stream frame of signed Dense scores; emits the winning
// class index, its score and a frame-length error flag as one output beat.
module dense_argmax_axis
  import dense_pkg::*;
#(
  parameter  int DATA_SIZE   = DENSE_DATA_SIZE,
  parameter  int CLASS_COUNT = DENSE_CLASS_COUNT,
  localparam int IDX_W       = $clog2(CLASS_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [IDX_W-1:0]     m_class,
  output logic [DATA_SIZE-1:0] m_score,
  output logic                 m_err,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [IDX_W-1:0]            r_cnt;
  logic [IDX_W-1:0]            r_best_idx;
  logic signed [DATA_SIZE-1:0] r_best_val;
  logic                        r_err;

  logic                        w_beat;
  logic                        w_cnt_last;
  logic                        w_take;

  assign s_ready    = (r_state != ST_OUTPUT);
  assign w_beat     = s_valid && s_ready;
  assign w_cnt_last = (r_cnt == LAST_IDX);
  // Strictly greater: ties keep the lowest index already held.
  assign w_take     = (r_cnt == '0) || ($signed(s_data) > r_best_val);

  assign m_valid = (r_state == ST_OUTPUT);
  assign m_class = r_best_idx;
  assign m_score = r_best_val;
  assign m_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ACCUM: begin
        if (w_beat) begin
          if (s_last) begin
            w_state_nxt = ST_OUTPUT;
          end else if (w_cnt_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_beat && s_last) begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (m_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // Beat counter saturates at the last index; an over-long frame parks in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ACCUM: begin
          if (w_beat) begin
            if (s_last) begin
              r_cnt <= '0;
              r_err <= !w_cnt_last;
            end else if (w_cnt_last) begin
              r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + IDX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_beat && s_last) begin
            r_cnt <= '0;
          end
        end
        ST_OUTPUT: begin
          if (m_ready) begin
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_idx <= '0;
      r_best_val <= '0;
    end else if ((r_state == ST_ACCUM) && w_beat && w_take) begin
      r_best_idx <= r_cnt;
      r_best_val <= $signed(s_data);
    end
  end

endmodule

// File: tb/tb_dense_argmax_axis.sv
// Directed and randomized frames for dense_argmax_axis, checked against an
// argmax reference model computed from the frame contents.
module tb_dense_argmax_axis;
  import dense_pkg::*;

  localparam int DW = DENSE_DATA_SIZE;
  localparam int CC = DENSE_CLASS_COUNT;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DW-1:0]          s_data = '0;
  logic                   s_valid = 1'b0;
  logic                   s_last = 1'b0;
  logic                   m_ready = 1'b1;
  logic                   s_ready;
  logic [$clog2(CC)-1:0]  m_class;
  logic [DW-1:0]          m_score;
  logic                   m_err;
  logic                   m_valid;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;
  int frm[$];

  dense_argmax_axis #(.DATA_SIZE(DW), .CLASS_COUNT(CC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_class (m_class),
    .m_score (m_score),
    .m_err   (m_err),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: argmax over the first CC scores received, lowest index on ties.
  function automatic void model(input int q[$], output int cls, output int sc, output bit err);
    int lim;
    lim = (q.size() < CC) ? q.size() : CC;
    cls = 0;
    sc  = q[0];
    for (int i = 1; i < lim; i++) begin
      if (q[i] > sc) begin
        sc  = q[i];
        cls = i;
      end
    end
    err = (q.size() != CC);
  endfunction

  // Entered and left at a falling edge; every beat is expected to be accepted at once.
  task automatic send_beats(input int n, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      s_data  = DW'(frm[i]);
      s_valid = 1'b1;
      s_last  = mark_last && (i == n - 1);
      chk("s_ready_beat", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frame(input int hold, input bit pre, input int pre_val);
    int            cls;
    int            sc;
    bit            err;
    logic [DW-1:0] es;
    model(frm, cls, sc, err);
    es = DW'(sc);
    chk("m_valid_rise", {31'd0, m_valid}, 32'd1);
    chk("m_class", {28'd0, m_class}, cls);
    chk("m_score", {16'd0, m_score}, {16'd0, es});
    chk("m_err", {31'd0, m_err}, {31'd0, err});
    if (pre) begin
      s_data  = DW'(pre_val);
      s_valid = 1'b1;
      s_last  = 1'b0;
    end
    for (int k = 0; k < hold; k++) begin
      chk("s_ready_hold", {31'd0, s_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("m_valid_hold", {31'd0, m_valid}, 32'd1);
      chk("m_class_hold", {28'd0, m_class}, cls);
      chk("m_score_hold", {16'd0, m_score}, {16'd0, es});
      chk("m_err_hold", {31'd0, m_err}, {31'd0, err});
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("m_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("s_ready_after", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic run_frame(input int hold);
    m_ready = (hold == 0);
    send_beats(frm.size(), 1'b1);
    finish_frame(hold, 1'b0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_class"}, {28'd0, m_class}, 32'd0);
    chk({tag, "_m_score"}, {16'd0, m_score}, 32'd0);
    chk({tag, "_m_err"}, {31'd0, m_err}, 32'd0);
  endtask

  initial begin
    int first_b;
    int n;
    int hold;
    int v;
    logic signed [DW-1:0] t;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    frm = '{3, -5, 7, 2, 0, 1, -1, 4, 6, 5};
    run_frame(0);

    frm = '{-8, -3, -3, -9, -10, -4, -5, -6, -7, -11};
    run_frame(0);

    frm = '{1, 9, 2, 3};
    run_frame(0);
    frm = '{2, 4, 11, -3, 0, 6, 11, 1, 5, 3};
    run_frame(0);

    frm = '{5, 3, 8, 1, 0, 2, 7, 6, 4, -1, 50, 2};
    run_frame(0);

    frm = '{4, 1, 0, 3, 2, 6, 5, 7, 8, 9};
    m_ready = 1'b0;
    send_beats(frm.size(), 1'b1);
    first_b = 20;
    finish_frame(5, 1'b1, first_b);
    frm = '{20, 1, 2, 3, 4, 5, 6, 7, 8, 20};
    run_frame(0);

    frm = '{7, 7, 7, 30, 7, 7, 7, 7, 7, 7};
    send_beats(5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_valid_after_reset", {31'd0, m_valid}, 32'd0);
    end
    frm = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_frame(0);

    for (int f = 0; f < 30; f++) begin
      n = ($urandom_range(0, 9) < 6) ? CC : int'($urandom_range(1, 14));
      hold = int'($urandom_range(0, 2));
      frm.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          v = int'($urandom_range(0, 6)) - 3;
        end else begin
          t = DW'($urandom);
          v = int'(t);
        end
        frm.push_back(v);
      end
      run_frame(hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
